// File: rtl/result_shift_out.sv
// -----------------------------------------------------------------------------
// result_shift_out
//
// Output-side partner of the bit-serial input loader. When start is seen in
// IDLE, the block waits FILL_CYCLES cycles for the input shift chain to fill.
// It then captures the compressor's parallel dst result in a single cycle and
// sends it LSB-first on one serial pin, using a valid/ready handshake.
//
// Optional build macro: RESULT_SHIFT_OUT_PARITY_EN
//   When defined, an even-parity bit (XOR of all captured bits) is appended
//   as an extra final bit, and ser_last moves onto that bit.
//   When undefined, a frame is exactly WIDTH bits long.
//
// Parameters:
//   WIDTH        number of dst bits captured and serialized (>= 2)
//   FILL_CYCLES  wait cycles between accepting start and sampling dst
//   CNT_W        width of the completed-frame counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      capture request, only looked at in IDLE
//   dst        parallel compressor result, dst[0] is column 0
//   busy       high whenever the block is not IDLE
//   ser_out    current serial data bit
//   ser_valid  ser_out holds a valid bit
//   ser_ready  downstream accepts the bit this cycle
//   ser_last   marks the final bit of a frame
//   frame_cnt  number of completed frames (wraps)
// -----------------------------------------------------------------------------
module result_shift_out #(
  parameter int WIDTH       = 32,
  parameter int FILL_CYCLES = 26,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dst,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int WAIT_W = (FILL_CYCLES > 0) ? $clog2(FILL_CYCLES + 1) : 1;
  localparam int IDX_W  = $clog2(WIDTH);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [WAIT_W-1:0] FILL_LOAD = WAIT_W'(FILL_CYCLES);

`ifdef RESULT_SHIFT_OUT_PARITY_EN
  typedef enum logic [1:0] {IDLE, FILL, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic               xfer;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
  logic               par_q, par_d;
`endif

  // A bit moves downstream whenever the presented bit is valid and accepted.
  assign xfer = ser_valid_q && ser_ready;

  // Next-state logic. The serial outputs are computed from the *next* state,
  // so they can be registered and still line up with the state they describe.
  // During a stall every _d equals its _q. That keeps ser_out, ser_valid and
  // ser_last frozen for as long as ser_ready stays low.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          wait_d  = FILL_LOAD;
        end
      end

      FILL: begin
        // Count down first. dst is sampled on the edge where the count is
        // already zero, which is FILL_CYCLES+1 edges after start was taken.
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          shreg_d = dst;
          idx_d   = '0;
          state_d = SHIFT;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
          par_d   = ^dst;
`endif
        end
      end

      SHIFT: begin
        if (xfer) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef RESULT_SHIFT_OUT_PARITY_EN
      PAR: begin
        if (xfer) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

`ifdef RESULT_SHIFT_OUT_PARITY_EN
    ser_valid_d = (state_d == SHIFT) || (state_d == PAR);
    ser_out_d   = ((state_d == SHIFT) && shreg_d[0]) ||
                  ((state_d == PAR) && par_d);
    ser_last_d  = (state_d == PAR);
`else
    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = (state_d == SHIFT) && shreg_d[0];
    ser_last_d  = (state_d == SHIFT) && (idx_d == LAST_IDX);
`endif
  end

  // All state and all outputs live in one register bank. A synchronous reset
  // drops any partial frame and clears the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
`ifdef RESULT_SHIFT_OUT_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign frame_cnt = cnt_q;

endmodule

// File: doc/result_shift_out.md
Name: result_shift_out

Overview:
- Output-side counterpart of the bit-serial input loader that feeds the compressor.
- On a start request, waits for the input shift registers to fill, then captures the compressor's parallel dst result in one cycle.
- Shifts the captured result out LSB-first on a single serial pin with a valid/ready handshake.
- Sits between the compressor's dst outputs and the chip-level serial output.

Parameters:
- WIDTH, 32, number of dst result bits captured and serialized (must be >= 2).
- FILL_CYCLES, 26, wait cycles between accepting start and sampling dst (input shift depth).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  capture request; sampled only in IDLE.
- dst  input  WIDTH  parallel compressor result; dst[0] is column 0.
- busy  output  1  high in any state other than IDLE.
- ser_out  output  1  current serial data bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts the bit this cycle.
- ser_last  output  1  high with the final bit of a frame.
- frame_cnt  output  CNT_W  count of completed frames.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0 (busy, ser_out, ser_valid, ser_last, frame_cnt); state IDLE; shift register and counters cleared.
- Reset mid-operation: any partial frame is discarded. No ser_valid in the cycle after rst deasserts.
- States: IDLE, FILL, SHIFT (plus PAR when PARITY_EN is defined).
- IDLE:
  - start=1 at an edge -> FILL; wait counter loaded with FILL_CYCLES.
  - start=0 -> stay IDLE.
- FILL:
  - Each edge decrements the wait counter while it is non-zero.
  - At the edge where the counter is 0: capture dst into the shift register, clear the bit index, go to SHIFT.
  - dst is therefore sampled on the (FILL_CYCLES+1)th edge after the start edge.
  - FILL_CYCLES=0 means capture on the edge immediately after start.
- SHIFT:
  - ser_valid=1, ser_out=shreg[0].
  - A transfer occurs on an edge with ser_valid&&ser_ready.
  - On each transfer: shreg shifts right one bit (zero fill) and the bit index increments.
  - ser_ready=0 holds ser_out, ser_valid and ser_last stable, with no limit on stall length.
  - ser_last=1 only while the bit index = WIDTH-1.
  - The transfer of bit WIDTH-1 returns the block to IDLE and increments frame_cnt (modulo 2^CNT_W, wraps to 0).
- Outside SHIFT/PAR: ser_valid=0, ser_out=0, ser_last=0.
- start while busy is ignored (not queued).
- start on the same edge the final transfer completes is ignored; start is re-sampled from the following cycle.
- ser_valid falls for at least one cycle between frames.
- dst may change freely except at the capture edge. The captured frame is immune to later dst changes.
- Back-to-back frames: minimum start-to-start spacing is FILL_CYCLES+1+WIDTH+1 cycles with ser_ready held high.

Optional Feature:
- Macro: RESULT_SHIFT_OUT_PARITY_EN.
- When defined:
  - The final data transfer goes to state PAR instead of IDLE, and ser_last stays 0 on data bit WIDTH-1.
  - PAR presents the even-parity bit (XOR of all WIDTH captured bits) with ser_valid=1 and ser_last=1, under the same handshake.
  - Its transfer returns the block to IDLE and increments frame_cnt.
  - Frame length is WIDTH+1 bits.
- When undefined: no PAR state or parity logic; frame length is WIDTH bits.

Test Plan:
- Reset: hold rst 3 cycles, release -> all outputs 0, busy=0, frame_cnt=0; no ser_valid for 10 idle cycles.
- Basic frame (FILL_CYCLES=26, ser_ready=1, dst=32'hA5C3_0F01, start pulsed 1 cycle):
  - dst sampled on edge 27 after start; ser_valid rises the cycle after.
  - 32 serial bits observed equal 1,0,0,0,0,0,0,0,1,1,1,1,... (LSB-first), ser_last on bit 31 only.
  - frame_cnt=1, busy drops immediately after.
- Backpressure: same frame with ser_ready toggling 1,0,0,1 pattern -> identical 32-bit sequence; ser_out/ser_valid/ser_last stable on every stalled cycle.
- Input isolation and start while busy:
  - Change dst to 32'hFFFF_FFFF one cycle after capture, and pulse start mid-SHIFT.
  - Frame still 32'hA5C3_0F01; no second frame; frame_cnt increments once.
- Reset mid-frame: assert rst after bit 10 transfers -> next cycle ser_valid=0, frame_cnt=0; new start yields a complete fresh frame.
- Parity (macro defined, dst=32'h0000_0007) -> 33 bits; bit 32 = 1 with ser_last=1; with dst=32'h0000_0003 bit 32 = 0.
